counting_seq_emitter: RTL and testbench
=======================================

// Module: counting_seq_emitter
// PURPOSE
//  Transmit side of the 2-bit symbol stream consumed by the counting detector.
//  On a start request it emits: PAD idle symbols (00), REP lead symbols (01), one 10, then one 11.
//  This drives a downstream counting detector from S0 to S3.
//  It sits between test/control logic and the detector's num input. A valid/ready handshake lets the consumer stall.
// PARAMETERS
//  PAD_W  4  width of pad_cnt; pads of 0..2^PAD_W-1 idle symbols
//  REP_W  3  width of rep_cnt; lead 01 repeated 1..2^REP_W-1 times (0 treated as 1)
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high; returns block to IDLE
//  start      in   1      request new sequence; accepted only when busy==0
//  pad_cnt    in   PAD_W  number of 00 symbols before first 01; sampled when start is accepted
//  rep_cnt    in   REP_W  number of 01 symbols; sampled when start is accepted
//  abort      in   1      synchronous cancel of the current sequence
//  num_out    out  2      current symbol; 2'b00 whenever out_valid==0
//  out_valid  out  1      num_out holds a symbol to be transferred
//  out_ready  in   1      consumer accepts; transfer happens when out_valid && out_ready at posedge
//  busy       out  1      high from the cycle after start is accepted until the return to IDLE
//  done       out  1      one-cycle pulse after the final 11 transfers
// BEHAVIOUR
//  Reset: state=IDLE; num_out=00, out_valid=0, busy=0, done=0; counters cleared.
//  FSM states: IDLE, PAD, LEAD, MID, TAIL, FIN. num_out in each state:
//   - PAD=00, LEAD=01, MID=10, TAIL=11.
//   - out_valid=1 in PAD/LEAD/MID/TAIL; 0 in IDLE/FIN.
//  IDLE -> PAD when start: latch pad_cnt, latch max(rep_cnt,1). If pad_cnt==0, go directly to LEAD.
//  Latency: first symbol is valid on the cycle after start is sampled.
//  A state advances only on a transfer (valid&&ready):
//   - PAD: decrement pad counter; on the last pad transfer -> LEAD.
//   - LEAD: decrement rep counter; on the last transfer -> MID.
//   - MID: on transfer -> TAIL.
//   - TAIL: on transfer -> FIN.
//   - FIN: done=1 for exactly one cycle, then -> IDLE.
//  Stall: while out_valid && !out_ready, num_out, state and counters hold unchanged.
//  Minimum sequence (pad=0, rep=1) is 3 transfers. Maximum is (2^PAD_W-1)+(2^REP_W-1)+2.
//  start while busy: ignored; no queueing, latched counts unchanged.
//  start in the FIN cycle: ignored. A new start is accepted from IDLE only.
//  abort in PAD..TAIL: next cycle IDLE, out_valid=0, done not asserted.
//   - abort has priority over a coincident transfer.
//   - abort in IDLE or FIN: no effect.
//  reset has priority over abort and start. Reset mid-sequence truncates the stream; no done pulse.
//  Counters are unsigned, compare to 1 for "last", and never wrap. The decrement happens only on a transfer.
// STRUCTURE
//  Shared package/header counting_defs: symbol codes SYM_IDLE=2'b00, SYM_A=2'b01, SYM_B=2'b10, SYM_C=2'b11.
//  The same header holds the emitter state encodings (3-bit).
//  The counting detector reuses these same symbol codes.
//  One sub-module: load_down_counter (parameterised width; load, dec enable, is_last flag).
//  It is instantiated twice, for pad and rep.
// TESTING
//  1 reset, then start with pad=0, rep=1, ready=1: num_out 01,10,11 on 3 consecutive cycles.
//    Then done pulses once; a counting detector fed num_out shows ans=1.
//  2 pad=3, rep=2, ready=1: stream 00,00,00,01,01,10,11 (7 transfers); busy high throughout; done one cycle after 11.
//  3 pad=1, rep=0, ready toggling 1,0,0,1,...: each symbol held stable while ready=0.
//    Stream is 00,01,10,11 (rep=0 acts as 1).
//  4 start pulsed again mid-sequence with different pad/rep: ignored; the original sequence completes unchanged.
//  5 abort during MID (num_out=10), ready=1: next cycle out_valid=0, num_out=00, busy=0, no done.
//    A following start runs cleanly.
//  6 reset asserted during LEAD with ready=0 and start=1: next cycle all outputs are at reset values.
//    The block then stays in IDLE.

Source files
------------

// File: rtl/counting_defs.sv
// counting_defs
//   Shared definitions for the counting symbol stream. The symbol codes are
//   common to the emitter and the counting detector. The emitter state
//   encoding is kept here as well, so that checkers and debug logic can
//   decode the state register.
package counting_defs;

  // 2-bit symbol codes on the num stream
  localparam logic [1:0] SYM_IDLE = 2'b00;
  localparam logic [1:0] SYM_A    = 2'b01;
  localparam logic [1:0] SYM_B    = 2'b10;
  localparam logic [1:0] SYM_C    = 2'b11;

  // Emitter FSM states (3-bit encoding)
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PAD  = 3'd1,
    ST_LEAD = 3'd2,
    ST_MID  = 3'd3,
    ST_TAIL = 3'd4,
    ST_FIN  = 3'd5
  } emit_state_e;

  // Symbol presented on num_out while the emitter sits in a given state.
  // IDLE and FIN present no symbol, so they map to SYM_IDLE.
  function automatic logic [1:0] sym_for_state(input emit_state_e st);
    logic [1:0] sym;
    case (st)
      ST_PAD:  sym = SYM_IDLE;
      ST_LEAD: sym = SYM_A;
      ST_MID:  sym = SYM_B;
      ST_TAIL: sym = SYM_C;
      default: sym = SYM_IDLE;
    endcase
    return sym;
  endfunction

  // True for the states that present a symbol to the consumer
  function automatic logic state_has_symbol(input emit_state_e st);
    logic v;
    case (st)
      ST_PAD, ST_LEAD, ST_MID, ST_TAIL: v = 1'b1;
      default:                          v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/counting_seq_emitter_counter.sv
// load_down_counter
//   Loadable down counter used to count the remaining pad and lead symbols.
//   Ports:
//     clk, reset  : clock and synchronous active-high reset (clears count)
//     load        : load load_val (has priority over dec)
//     load_val    : value to load
//     dec         : decrement by one; saturates at zero and never wraps
//     is_last     : count equals one, i.e. the current symbol is the last
//   W must be at least 2.
module load_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         is_last
);

  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO = {W{1'b0}};

  logic [W-1:0] cnt_r;

  // Count register: load, otherwise saturating decrement
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= ZERO;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != ZERO)) begin
      cnt_r <= cnt_r - ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign is_last = (cnt_r == ONE);

endmodule

// File: rtl/counting_seq_emitter.sv
// counting_seq_emitter
//   Transmit side of the 2-bit symbol stream consumed by the counting
//   detector. A start request produces pad_cnt idle symbols (00), then
//   max(rep_cnt,1) lead symbols (01), one 10 and one 11, with a valid/ready
//   handshake so that the consumer can stall the stream.
//   Ports:
//     clk, reset : clock and synchronous active-high reset
//     start      : request a new sequence (accepted only in IDLE)
//     pad_cnt    : number of 00 symbols, sampled when start is accepted
//     rep_cnt    : number of 01 symbols (0 acts as 1), sampled with start
//     abort      : cancel the running sequence, no done pulse
//     num_out    : current symbol, 00 whenever out_valid is low
//     out_valid  : num_out holds a symbol to transfer
//     out_ready  : consumer accepts; transfer on out_valid && out_ready
//     busy       : a sequence is in progress (including the FIN cycle)
//     done       : one-cycle pulse after the final 11 has transferred
module counting_seq_emitter
  import counting_defs::*;
#(
  parameter int PAD_W = 4,
  parameter int REP_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAD_W-1:0] pad_cnt,
  input  logic [REP_W-1:0] rep_cnt,
  input  logic             abort,
  output logic [1:0]       num_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  emit_state_e      state_r;
  emit_state_e      next_state_s;
  logic             xfer_s;
  logic             pad_load_s;
  logic             pad_dec_s;
  logic             pad_last_s;
  logic             rep_load_s;
  logic             rep_dec_s;
  logic             rep_last_s;
  logic [REP_W-1:0] rep_load_val_s;

  assign xfer_s = out_valid && out_ready;

  // A lead count of zero still emits one 01 symbol
  assign rep_load_val_s = (rep_cnt == {REP_W{1'b0}}) ? {{(REP_W-1){1'b0}}, 1'b1} : rep_cnt;

  load_down_counter #(.W(PAD_W)) u_pad_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (pad_load_s),
    .load_val (pad_cnt),
    .dec      (pad_dec_s),
    .is_last  (pad_last_s)
  );

  load_down_counter #(.W(REP_W)) u_rep_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (rep_load_s),
    .load_val (rep_load_val_s),
    .dec      (rep_dec_s),
    .is_last  (rep_last_s)
  );

  // Next-state and counter control; abort outranks a coincident transfer
  always_comb begin
    next_state_s = state_r;
    pad_load_s   = 1'b0;
    pad_dec_s    = 1'b0;
    rep_load_s   = 1'b0;
    rep_dec_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          pad_load_s = 1'b1;
          rep_load_s = 1'b1;
          if (pad_cnt == {PAD_W{1'b0}}) begin
            next_state_s = ST_LEAD;
          end else begin
            next_state_s = ST_PAD;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_PAD: begin
        if (abort) begin
          next_state_s = ST_IDLE;
        end else if (xfer_s) begin
          pad_dec_s = 1'b1;
          if (pad_last_s) begin
            next_state_s = ST_LEAD;
          end else begin
            next_state_s = ST_PAD;
          end
        end else begin
          next_state_s = ST_PAD;
        end
      end
      ST_LEAD: begin
        if (abort) begin
          next_state_s = ST_IDLE;
        end else if (xfer_s) begin
          rep_dec_s = 1'b1;
          if (rep_last_s) begin
            next_state_s = ST_MID;
          end else begin
            next_state_s = ST_LEAD;
          end
        end else begin
          next_state_s = ST_LEAD;
        end
      end
      ST_MID: begin
        if (abort) begin
          next_state_s = ST_IDLE;
        end else if (xfer_s) begin
          next_state_s = ST_TAIL;
        end else begin
          next_state_s = ST_MID;
        end
      end
      ST_TAIL: begin
        if (abort) begin
          next_state_s = ST_IDLE;
        end else if (xfer_s) begin
          next_state_s = ST_FIN;
        end else begin
          next_state_s = ST_TAIL;
        end
      end
      ST_FIN: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Registered outputs decoded from the next state, so they always
  // describe the state the FSM is in during the following cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      num_out   <= SYM_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      num_out   <= sym_for_state(next_state_s);
      out_valid <= state_has_symbol(next_state_s);
      busy      <= (next_state_s != ST_IDLE);
      done      <= (next_state_s == ST_FIN);
    end
  end

endmodule

// File: tb/tb_counting_seq_emitter.sv
module tb_counting_seq_emitter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] pad_cnt = 4'd0;
  logic [2:0] rep_cnt = 3'd0;
  logic       abort = 1'b0;
  logic [1:0] num_out;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       done;

  int passed = 0;
  int total  = 0;

  counting_seq_emitter #(.PAD_W(4), .REP_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pad_cnt   (pad_cnt),
    .rep_cnt   (rep_cnt),
    .abort     (abort),
    .num_out   (num_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // phase: 0 = idle, 1 = streaming symbols from m_q, 2 = finishing
  int         m_phase = 0;
  logic [1:0] m_q[$];
  logic [1:0] cap_q[$];

  task automatic model_step();
    if (reset) begin
      m_q.delete();
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (start) begin
        int reps;
        reps = (rep_cnt == 3'd0) ? 1 : int'(rep_cnt);
        m_q.delete();
        for (int i = 0; i < int'(pad_cnt); i++) m_q.push_back(2'b00);
        for (int i = 0; i < reps; i++) m_q.push_back(2'b01);
        m_q.push_back(2'b10);
        m_q.push_back(2'b11);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (abort) begin
        m_q.delete();
        m_phase = 0;
      end else if (out_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  task automatic check_model();
    logic       v;
    logic [1:0] s;
    v = (m_phase == 1);
    s = v ? m_q[0] : 2'b00;
    chk("num_out", {2'b00, num_out}, {2'b00, s});
    chk("out_valid", {3'b000, out_valid}, {3'b000, v});
    chk("busy", {3'b000, busy}, {3'b000, (m_phase != 0)});
    chk("done", {3'b000, done}, {3'b000, (m_phase == 2)});
  endtask

  // One clock: record any transfer, advance model, then sample outputs
  task automatic tick(input bit do_check);
    if (out_valid === 1'b1 && out_ready === 1'b1) cap_q.push_back(num_out);
    @(posedge clk);
    model_step();
    #1;
    if (do_check) check_model();
  endtask

  task automatic run_until_done(input string name, input int budget, input int ready_mode);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (ready_mode == 0) out_ready = 1'b1;
      else out_ready = ((i % 3) == 0);
      tick(1'b1);
      start = 1'b0;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, {3'b000, seen}, 4'd1);
  endtask

  task automatic compare_stream(input string name, input logic [1:0] exp_q[$]);
    chk({name, "_len"}, 4'(cap_q.size()), 4'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      chk(name, {2'b00, cap_q[i]}, {2'b00, exp_q[i]});
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       rst;
    logic       st;
    logic       ab;
    logic       rdy;
    logic [3:0] pad;
    logic [2:0] rep;
    logic [1:0] e_num;
    logic       e_valid;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic st, logic ab, logic rdy, logic [3:0] pad,
                              logic [2:0] rep, logic [1:0] n, logic v, logic b, logic d);
    vec_t r;
    r.rst = rst; r.st = st; r.ab = ab; r.rdy = rdy; r.pad = pad; r.rep = rep;
    r.e_num = n; r.e_valid = v; r.e_busy = b; r.e_done = d;
    return r;
  endfunction

  initial begin
    logic [1:0] exp_s[$];

    // reset, then minimal sequence pad=0 rep=1
    vecs.push_back(mk(1, 0, 0, 1, 4'd0, 3'd1, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 4'd0, 3'd1, 2'b01, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 4'd0, 3'd1, 2'b10, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 4'd0, 3'd1, 2'b11, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 4'd0, 3'd1, 2'b00, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 1, 4'd0, 3'd1, 2'b00, 0, 0, 0)); // start in FIN ignored
    // abort during MID, then a clean pad=1 rep=0 run with one stall
    vecs.push_back(mk(0, 1, 0, 1, 4'd0, 3'd1, 2'b01, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 4'd0, 3'd1, 2'b10, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 4'd0, 3'd1, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 4'd1, 3'd0, 2'b00, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 4'd1, 3'd0, 2'b01, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'd1, 3'd0, 2'b01, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 4'd1, 3'd0, 2'b10, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 4'd1, 3'd0, 2'b11, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 4'd1, 3'd0, 2'b00, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 4'd1, 3'd0, 2'b00, 0, 0, 0));
    // reset during LEAD with ready=0 and start=1
    vecs.push_back(mk(0, 1, 0, 1, 4'd0, 3'd3, 2'b01, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'd0, 3'd3, 2'b01, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 4'd0, 3'd3, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'd0, 3'd3, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 4'd0, 3'd3, 2'b00, 0, 0, 0)); // abort in IDLE

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; start = vecs[i].st; abort = vecs[i].ab;
      out_ready = vecs[i].rdy; pad_cnt = vecs[i].pad; rep_cnt = vecs[i].rep;
      tick(1'b0);
      chk($sformatf("vec%0d_num", i), {2'b00, num_out}, {2'b00, vecs[i].e_num});
      chk($sformatf("vec%0d_valid", i), {3'b000, out_valid}, {3'b000, vecs[i].e_valid});
      chk($sformatf("vec%0d_busy", i), {3'b000, busy}, {3'b000, vecs[i].e_busy});
      chk($sformatf("vec%0d_done", i), {3'b000, done}, {3'b000, vecs[i].e_done});
    end
    reset = 1'b0; start = 1'b0; abort = 1'b0;

    // pad=3 rep=2, ready held high
    cap_q.delete();
    pad_cnt = 4'd3; rep_cnt = 3'd2; start = 1'b1;
    run_until_done("t2_done", 40, 0);
    exp_s = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
    compare_stream("t2_stream", exp_s);
    tick(1'b1);

    // pad=1 rep=0, ready toggling
    cap_q.delete();
    pad_cnt = 4'd1; rep_cnt = 3'd0; start = 1'b1;
    run_until_done("t3_done", 60, 1);
    exp_s = '{2'b00, 2'b01, 2'b10, 2'b11};
    compare_stream("t3_stream", exp_s);
    tick(1'b1);

    // start re-pulsed mid-sequence with other counts is ignored
    cap_q.delete();
    out_ready = 1'b1; pad_cnt = 4'd2; rep_cnt = 3'd3; start = 1'b1;
    tick(1'b1);
    start = 1'b0;
    tick(1'b1);
    pad_cnt = 4'd5; rep_cnt = 3'd1; start = 1'b1;
    tick(1'b1);
    start = 1'b0;
    run_until_done("t4_done", 40, 0);
    exp_s = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11};
    compare_stream("t4_stream", exp_s);
    tick(1'b1);

    // maximum-length sequence
    cap_q.delete();
    pad_cnt = 4'd15; rep_cnt = 3'd7; start = 1'b1;
    run_until_done("tmax_done", 60, 0);
    chk("tmax_len", 5'(cap_q.size()) == 5'd24 ? 4'd1 : 4'd0, 4'd1);
    tick(1'b1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 3) == 0);
      abort     = ($urandom_range(0, 59) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      pad_cnt   = 4'($urandom_range(0, 15));
      rep_cnt   = 3'($urandom_range(0, 7));
      tick(1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
